// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALU control codes, ALUOp and M-op encodings, sequencer states shared by EX-stage logic.
package alu_ctrl_pkg;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SRA  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_MUL  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [1:0] OP_I  = 2'b00;
  localparam logic [1:0] OP_BR = 2'b01;
  localparam logic [1:0] OP_R  = 2'b10;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  // alt is funct7[5]; it selects sub only for register-register forms
  function automatic logic [3:0] alu_f3(input logic [2:0] f3, input logic alt, input logic rtype);
    case (f3)
      3'b000:  alu_f3 = (rtype && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_f3 = ALU_SLL;
      3'b010:  alu_f3 = ALU_SLT;
      3'b011:  alu_f3 = ALU_SLTU;
      3'b100:  alu_f3 = ALU_XOR;
      3'b101:  alu_f3 = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_f3 = ALU_OR;
      default: alu_f3 = ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: radix-2 shift-add multiply / restoring divide datapath on operand magnitudes, with sign fix.
module muldiv_iter
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            step_i,
  input  logic            last_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            special_o,
  output logic [XLEN-1:0] result_o
);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  logic [2:0] op_q;
  logic neg_q, sgn1, sgn2, neg_n, div_zero, ovf;
  logic [XLEN-1:0] a_q, mag1, mag2, special_res, q_fix, r_fix, res_n;
  logic [2*XLEN-1:0] p_q, p_n, p_fix;
  logic [XLEN:0] sum, rem_sh, diff;
  // p_q holds {product_hi, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    sgn1 = rs1_i[XLEN-1] && (op_i == MD_MULH || op_i == MD_MULHSU || op_i == MD_DIV || op_i == MD_REM);
    sgn2 = rs2_i[XLEN-1] && (op_i == MD_MULH || op_i == MD_DIV || op_i == MD_REM);
    mag1 = sgn1 ? -rs1_i : rs1_i;
    mag2 = sgn2 ? -rs2_i : rs2_i;
    neg_n = op_i == MD_REM ? sgn1 : sgn1 ^ sgn2;
    div_zero = op_i[2] && rs2_i == '0;
    ovf = (op_i == MD_DIV || op_i == MD_REM) && rs1_i == MIN && rs2_i == '1;
    special_o = div_zero || ovf;
    special_res = op_i[1] ? (div_zero ? rs1_i : '0) : (div_zero ? '1 : MIN);
    sum = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, a_q} : '0);
    rem_sh = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
    diff = rem_sh - {1'b0, a_q};
    p_n = op_q[2] ? (diff[XLEN] ? {rem_sh[XLEN-1:0], p_q[XLEN-2:0], 1'b0}
                                : {diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1})
                  : {sum, p_q[XLEN-1:1]};
    p_fix = neg_q ? -p_n : p_n;
    q_fix = neg_q ? -p_n[XLEN-1:0] : p_n[XLEN-1:0];
    r_fix = neg_q ? -p_n[2*XLEN-1:XLEN] : p_n[2*XLEN-1:XLEN];
    res_n = op_q == MD_MUL ? p_fix[XLEN-1:0] : !op_q[2] ? p_fix[2*XLEN-1:XLEN] : op_q[1] ? r_fix : q_fix;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_q <= '0;
      neg_q <= 1'b0;
      a_q <= '0;
      p_q <= '0;
      result_o <= '0;
    end else begin
      if (start_i) begin
        op_q <= op_i;
        neg_q <= neg_n;
        a_q <= mag2;
        p_q <= {{XLEN{1'b0}}, mag1};
      end else if (step_i) begin
        p_q <= p_n;
      end
      if (start_i && special_o) result_o <= special_res;
      else if (step_i && last_i) result_o <= res_n;
    end
  end
endmodule

// File: rtl/alu_muldiv_ctrl.sv
// alu_muldiv_ctrl: RV32 EX-stage ALU control decode plus iterative M-extension sequencer with pipeline stall.
module alu_muldiv_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [31:0]     funct_i,
  input  logic [1:0]      ALUOp_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [3:0]      ALUCtrl_o,
  output logic            md_sel_o,
  output logic            stall_o,
  output logic            md_valid_o,
  output logic [XLEN-1:0] md_result_o
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic accept, special, unused_funct;
  assign unused_funct = ^{funct_i[24:15], funct_i[11:0]};
  always_comb begin
    md_sel_o = ALUOp_i == OP_R && funct_i[31:25] == F7_MULDIV;
    ALUCtrl_o = ALUOp_i == OP_I  ? alu_f3(funct_i[14:12], funct_i[30], 1'b0)
              : ALUOp_i == OP_BR ? ALU_SUB
              : ALUOp_i == OP_R  ? (md_sel_o ? ALU_MUL : alu_f3(funct_i[14:12], funct_i[30], 1'b1))
              : ALU_ADD;
  end
  assign accept = state == IDLE && valid_i && md_sel_o && !flush_i;
  assign stall_o = rst_i && (accept || (state == BUSY && !flush_i));
  assign md_valid_o = state == DONE && !flush_i;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      cnt <= '0;
    end else if (flush_i && state != IDLE) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state <= special ? DONE : BUSY;
          cnt <= CNT_W'(XLEN);
        end
        BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .start_i(accept),
    .step_i(state == BUSY && !flush_i),
    .last_i(cnt == CNT_W'(1)),
    .op_i(funct_i[14:12]),
    .rs1_i(rs1_i),
    .rs2_i(rs2_i),
    .special_o(special),
    .result_o(md_result_o)
  );
endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// tb_alu_muldiv_ctrl: directed checks of decode, M-op results/latency, flush, async reset and back-to-back issue.
module tb_alu_muldiv_ctrl;
  logic clk = 1'b0, rst_i = 1'b0, valid_i = 1'b0, flush_i = 1'b0;
  logic [31:0] funct_i = '0, rs1_i = '0, rs2_i = '0, md_result_o;
  logic [1:0] ALUOp_i = '0;
  logic [3:0] ALUCtrl_o;
  logic md_sel_o, stall_o, md_valid_o;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  alu_muldiv_ctrl #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i), .funct_i(funct_i),
    .ALUOp_i(ALUOp_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .ALUCtrl_o(ALUCtrl_o), .md_sel_o(md_sel_o),
    .stall_o(stall_o), .md_valid_o(md_valid_o), .md_result_o(md_result_o)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic dec(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                     input logic [3:0] exp_ctrl, input logic exp_sel, input string tag);
    ALUOp_i = op;
    funct_i = {f7, 10'd0, f3, 12'd0};
    #1;
    chk({tag, "_ctrl"}, 32'(ALUCtrl_o), 32'(exp_ctrl));
    chk({tag, "_sel"}, 32'(md_sel_o), 32'(exp_sel));
  endtask
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    valid_i = 1'b1;
    ALUOp_i = 2'b10;
    funct_i = {7'b0000001, 10'd0, f3, 12'd0};
    rs1_i = a;
    rs2_i = b;
  endtask
  task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string tag);
    int n, st;
    issue(f3, a, b);
    n = 0;
    st = 0;
    #1;
    while (!md_valid_o && n < 60) begin
      if (stall_o) st++;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_stallcyc"}, 32'(st), 32'(lat));
    chk({tag, "_res"}, md_result_o, exp);
    chk({tag, "_stall_done"}, 32'(stall_o), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_strobe1"}, 32'(md_valid_o), 32'd0);
  endtask
  initial begin
    int pulses, first, second;
    #2;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_valid", 32'(md_valid_o), 32'd0);
    chk("rst_result", md_result_o, 32'd0);
    @(negedge clk);
    rst_i = 1'b1;
    dec(2'b10, 7'b0100000, 3'b000, 4'b0010, 1'b0, "r_sub");
    dec(2'b10, 7'b0000000, 3'b000, 4'b0000, 1'b0, "r_add");
    dec(2'b00, 7'b0100000, 3'b101, 4'b0001, 1'b0, "i_sra");
    dec(2'b00, 7'b0100000, 3'b000, 4'b0000, 1'b0, "i_addi_f7");
    dec(2'b00, 7'b0000000, 3'b011, 4'b1010, 1'b0, "i_sltu");
    dec(2'b00, 7'b0000000, 3'b010, 4'b1001, 1'b0, "i_slt");
    dec(2'b10, 7'b0000000, 3'b101, 4'b1000, 1'b0, "r_srl");
    dec(2'b10, 7'b0000000, 3'b111, 4'b0101, 1'b0, "r_and");
    dec(2'b10, 7'b0000000, 3'b001, 4'b0111, 1'b0, "r_sll");
    dec(2'b10, 7'b0000000, 3'b100, 4'b0100, 1'b0, "r_xor");
    dec(2'b10, 7'b0000000, 3'b110, 4'b0110, 1'b0, "r_or");
    dec(2'b10, 7'b0000001, 3'b100, 4'b0011, 1'b1, "r_mdiv");
    dec(2'b01, 7'b0000000, 3'b111, 4'b0010, 1'b0, "branch");
    dec(2'b11, 7'b0000001, 3'b101, 4'b0000, 1'b0, "reserved");
    run_md(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul");
    run_md(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu");
    run_md(3'b001, 32'h80000000, 32'd2, 32'hFFFFFFFF, 33, "mulh");
    run_md(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, "mulhsu");
    run_md(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, "div");
    run_md(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, "rem");
    run_md(3'b111, 32'd100, 32'd7, 32'd2, 33, "remu");
    run_md(3'b101, 32'd100, 32'd0, 32'hFFFFFFFF, 1, "divu0");
    run_md(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");
    run_md(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, "rem_ovf");
    run_md(3'b110, 32'h00001234, 32'd0, 32'h00001234, 1, "rem0");
    issue(3'b000, 32'd9, 32'd9);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    chk("busy_stall", 32'(stall_o), 32'd1);
    flush_i = 1'b1;
    #1;
    chk("flush_stall_comb", 32'(stall_o), 32'd0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    chk("flush_valid", 32'(md_valid_o), 32'd0);
    chk("flush_stall_idle", 32'(stall_o), 32'd0);
    run_md(3'b000, 32'd5, 32'd6, 32'd30, 33, "mul_after_flush");
    issue(3'b101, 32'd1000, 32'd3);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst_i = 1'b0;
    #1;
    chk("arst_stall", 32'(stall_o), 32'd0);
    chk("arst_valid", 32'(md_valid_o), 32'd0);
    chk("arst_result", md_result_o, 32'd0);
    @(negedge clk);
    rst_i = 1'b1;
    issue(3'b100, 32'd100, 32'd7);
    pulses = 0;
    first = 0;
    second = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (md_valid_o) begin
        pulses++;
        if (pulses == 1) first = i;
        if (pulses == 2) begin
          second = i;
          valid_i = 1'b0;
          chk("b2b_res", md_result_o, 32'd14);
        end
      end
    end
    chk("b2b_pulses", 32'(pulses), 32'd2);
    chk("b2b_first", 32'(first), 32'd33);
    chk("b2b_second", 32'(second), 32'd67);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_muldiv_ctrl.md
Name: alu_muldiv_ctrl

Overview:
Next-generation ALU control for the RV32 EX stage. It decodes ALUOp/funct fields into a 4-bit ALU control code covering the full RV32I ALU set, with a defined default and no inferred latches. It also owns an iterative multiply/divide sequencer for the M-extension. While that sequencer is busy it stalls the pipeline through the hazard unit, then presents a one-cycle result strobe to the EX result mux.

Parameters:
XLEN, 32, operand/result width (multiple of 2, ≥8)
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-low
valid_i  input  1  EX stage holds a valid instruction
flush_i  input  1  EX stage flushed (branch/exception); aborts any M op
funct_i  input  32  instruction word (uses [31:25], [14:12])
ALUOp_i  input  2  00 I-type, 01 branch, 10 R-type, 11 reserved
rs1_i  input  XLEN  operand A
rs2_i  input  XLEN  operand B
ALUCtrl_o  output  4  ALU operation code
md_sel_o  output  1  current instruction is an M op (EX mux selects md_result_o)
stall_o  output  1  hold IF/ID/EX, bubble MEM
md_valid_o  output  1  one-cycle strobe, md_result_o valid
md_result_o  output  XLEN  multiply/divide result

Behaviour:
- Reset (rst_i=0, async): state=IDLE, counter=0, all internal regs 0, md_valid_o=0, md_result_o=0, stall_o=0.
- Decode (combinational, every cycle). Codes: add 0000, sra 0001, sub 0010, mul-class 0011, xor 0100, and 0101, or 0110, sll 0111, srl 1000, slt 1001, sltu 1010.
- ALUOp 00: f3 000→add, 001→sll, 010→slt, 011→sltu, 100→xor, 101→funct7[5] ? sra : srl, 110→or, 111→and.
- ALUOp 01 → sub.
- ALUOp 10, funct7=0000001 → 0011 with md_sel_o=1. Other funct7 values decode as the I-type f3 map, with f3 000 → funct7[5] ? sub : add.
- Any undefined combination, including ALUOp 11 → add, md_sel_o=0.
- M op (f3): 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- FSM IDLE→BUSY→DONE→IDLE.
- IDLE: on valid_i & md_sel_o & !flush_i, latch operands and op and go to BUSY. If a special case applies, go to DONE directly instead. stall_o = valid_i & md_sel_o & !flush_i (combinational).
- Operand latching: take magnitudes of signed operands and record the result sign. For mulhsu only rs1 is signed. Clear the accumulator and set counter=XLEN.
- BUSY: one radix-2 step per cycle and decrement counter. stall_o=1.
  - Multiply: shift-add into a 2·XLEN product.
  - Divide: restoring shift-subtract.
  - When counter reaches 1, the next state is DONE. This gives exactly XLEN cycles in BUSY.
- DONE: apply the sign fix, drive md_result_o, md_valid_o=1 for one cycle, stall_o=0 (the pipeline advances this cycle), then go to IDLE unconditionally. A held valid_i is not re-accepted in DONE.
- Latency: accept edge → md_valid_o high XLEN+1 cycles later. Special cases give 1 cycle.
- Result selection: mul→product[XLEN-1:0]; mulh/mulhsu/mulhu→product[2XLEN-1:XLEN]; div/divu→quotient; rem/remu→remainder. Remainder sign follows the dividend.
- Special cases (resolved at accept, no iterations):
  - divisor=0: quotient all-ones, remainder=rs1.
  - Signed div with rs1=MIN and rs2=−1: quotient=MIN, remainder=0.
- flush_i in BUSY or DONE: go to IDLE next edge, md_valid_o=0, stall_o drops combinationally. In IDLE, flush_i blocks acceptance.
- md_result_o holds its value until the next DONE.

Decomposition:
- Shared package alu_ctrl_pkg: ALU code localparams, ALUOp encodings, M-op f3 encodings, FSM state encodings. The ALU datapath imports the same codes.
- One sub-module, muldiv_iter: the datapath (operand regs, accumulator, shift/add/sub, sign fix).
- Decode and FSM stay in the top module.

Test Plan:
- Decode sweep: ALUOp 10, f3 000, funct7 0100000 → ALUCtrl_o=0010, md_sel_o=0. ALUOp 00, f3 101, funct7 0100000 → 0001. ALUOp 11 → 0000.
- mul, rs1=7, rs2=−3 → stall_o high 33 cycles, md_valid_o at cycle 33, md_result_o=0xFFFFFFEB.
- mulhu, rs1=rs2=0xFFFFFFFF → md_result_o=0xFFFFFFFE. mulh, rs1=0x80000000, rs2=2 → 0xFFFFFFFF.
- div −7/2 → 0xFFFFFFFD. rem −7/2 → 0xFFFFFFFF. divu 100/0 → 0xFFFFFFFF in 1 cycle. div 0x80000000/−1 → 0x80000000. rem by 0 → rs1.
- flush_i asserted at BUSY cycle 10 → IDLE next edge, no md_valid_o, stall_o=0. A new mul accepted the following cycle completes correctly.
- rst_i low mid-BUSY → outputs 0 immediately, with no clock edge needed. Back-to-back div with valid_i held through DONE → exactly one md_valid_o per accepted op.
